sprite_draw_sequencer: RTL and testbench

//  Initiator side of the sprite plot handshake: owns the VGA adapter write port and, once per frame,

---
 rtl/sprite_draw_sequencer_pkg.sv | 24 ++
 rtl/sprite_draw_sequencer_frame_timer.sv | 33 +++
 rtl/sprite_draw_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared definitions for the sprite draw path: FSM state encoding, pixel
// field widths, default screen geometry and background colour constants.
// The width and colour constants are also used by the sprite plotters.
package sprite_draw_sequencer_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam logic [C_W-1:0] BG_BLACK = 3'b000;
    localparam logic [C_W-1:0] BG_WHITE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SELECT = 3'd2,
        S_DRAW   = 3'd3,
        S_FDONE  = 3'd4
    } draw_state_t;

endpackage

// File: rtl/sprite_draw_sequencer_frame_timer.sv
// Free-running frame timer: counts 0..FRAME_CYCLES-1 and emits a one-cycle
// tick while the count sits at 0 after each wrap.
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset (count and tick cleared)
//   tick    one-cycle frame pulse
module sprite_draw_sequencer_frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (count == LAST);
            if (count == LAST)
                count <= '0;
            else
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Owns the VGA adapter write port. Once per frame tick it optionally sweeps
// the screen with the background colour, then enables each active sprite
// plotter in slot order, forwarding its pixel stream until it reports done
// (or the watchdog gives up on it).
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   sprite_active/done/x/y/colour    per-slot plotter interface (packed, slot k at k*width)
//   sprite_enable                    one-hot or zero plotter enables
//   vga_x/y/colour/plot              registered adapter write port
//   frame_done                       one-cycle pulse at end of frame
//   busy                             high outside S_IDLE
//   overrun, timeout_err             sticky error flags
module sprite_draw_sequencer
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int             NUM_SPRITES  = 4,
    parameter int             FRAME_CYCLES = 833333,
    parameter int             CLEAR_EN     = 1,
    parameter int             SCREEN_W     = SCREEN_W_DEF,
    parameter int             SCREEN_H     = SCREEN_H_DEF,
    parameter logic [C_W-1:0] BG_COLOUR    = BG_BLACK,
    parameter int             TIMEOUT      = 1023
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_SPRITES-1:0]     sprite_active,
    input  logic [NUM_SPRITES-1:0]     sprite_done,
    input  logic [X_W*NUM_SPRITES-1:0] sprite_x,
    input  logic [Y_W*NUM_SPRITES-1:0] sprite_y,
    input  logic [C_W*NUM_SPRITES-1:0] sprite_colour,
    output logic [NUM_SPRITES-1:0]     sprite_enable,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int CXW  = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int CYW  = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int IDXW = $clog2(NUM_SPRITES + 1);

    localparam logic [CXW-1:0]  CX_LAST = CXW'(SCREEN_W - 1);
    localparam logic [CYW-1:0]  CY_LAST = CYW'(SCREEN_H - 1);
    localparam logic [WDW-1:0]  WD_LOAD = WDW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] IDX_END = IDXW'(NUM_SPRITES);

    draw_state_t     state;
    logic [IDXW-1:0] idx;
    logic [SW-1:0]   slot;
    logic [CXW-1:0]  cx;
    logic [CYW-1:0]  cy;
    logic [WDW-1:0]  wd;
    logic            tick;

    logic [X_W-1:0] x_arr [NUM_SPRITES];
    logic [Y_W-1:0] y_arr [NUM_SPRITES];
    logic [C_W-1:0] c_arr [NUM_SPRITES];

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_unpack
        assign x_arr[k] = sprite_x[X_W*k +: X_W];
        assign y_arr[k] = sprite_y[Y_W*k +: Y_W];
        assign c_arr[k] = sprite_colour[C_W*k +: C_W];
    end

    // idx runs one past the last slot to signal end of frame; slot is only
    // used to index when idx is a real slot
    assign slot = idx[SW-1:0];

    sprite_draw_sequencer_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idx           <= '0;
            cx            <= '0;
            cy            <= '0;
            wd            <= '0;
            sprite_enable <= '0;
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            vga_plot   <= 1'b0;
            frame_done <= 1'b0;

            // a tick that lands mid-frame is dropped, never queued
            if (tick && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        cx    <= '0;
                        cy    <= '0;
                        busy  <= 1'b1;
                        state <= (CLEAR_EN != 0) ? S_CLEAR : S_SELECT;
                    end
                end

                S_CLEAR: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= X_W'(cx);
                    vga_y      <= Y_W'(cy);
                    vga_colour <= BG_COLOUR;
                    if (cx == CX_LAST) begin
                        cx <= '0;
                        if (cy == CY_LAST) begin
                            cy    <= '0;
                            state <= S_SELECT;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end

                S_SELECT: begin
                    if (idx == IDX_END) begin
                        frame_done <= 1'b1;
                        state      <= S_FDONE;
                    end else if (sprite_active[slot]) begin
                        sprite_enable[slot] <= 1'b1;
                        wd                  <= WD_LOAD;
                        state               <= S_DRAW;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DRAW: begin
                    // the done cycle still carries the plotter's final pixel
                    vga_plot   <= 1'b1;
                    vga_x      <= x_arr[slot];
                    vga_y      <= y_arr[slot];
                    vga_colour <= c_arr[slot];
                    // enable drops on the same edge so the plotter sees it low
                    // when it returns to its wait state and does not restart
                    if (sprite_done[slot] || wd == '0) begin
                        if (!sprite_done[slot])
                            timeout_err <= 1'b1;
                        sprite_enable <= '0;
                        idx           <= idx + 1'b1;
                        state         <= S_SELECT;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end

                S_FDONE: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    sprite_enable <= '0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
module tb_sprite_draw_sequencer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance a: clear sweep, no sprites
    logic       rst_a;
    logic [3:0] a_en;
    logic [8:0] a_vx;
    logic [7:0] a_vy;
    logic [2:0] a_vc;
    logic       a_plot, a_fd, a_busy, a_ov, a_to;

    sprite_draw_sequencer #(
        .NUM_SPRITES(4), .FRAME_CYCLES(4000), .CLEAR_EN(1),
        .SCREEN_W(8), .SCREEN_H(4), .BG_COLOUR(3'b000), .TIMEOUT(600)
    ) dut_a (
        .clk(clk), .resetn(rst_a),
        .sprite_active(4'b0000), .sprite_done(4'b1111),
        .sprite_x(36'd0), .sprite_y(32'd0), .sprite_colour(12'd0),
        .sprite_enable(a_en), .vga_x(a_vx), .vga_y(a_vy), .vga_colour(a_vc),
        .vga_plot(a_plot), .frame_done(a_fd), .busy(a_busy),
        .overrun(a_ov), .timeout_err(a_to)
    );

    // instances b (index 0, FRAME_CYCLES=4000) and c (index 1, FRAME_CYCLES=1000)
    logic        rst_m  [2];
    logic [3:0]  m_act  [2];
    logic [3:0]  m_en   [2];
    logic [3:0]  m_done [2];
    logic [35:0] m_x    [2];
    logic [31:0] m_y    [2];
    logic [11:0] m_c    [2];
    logic [8:0]  vx     [2];
    logic [7:0]  vy     [2];
    logic [2:0]  vc     [2];
    logic        plot   [2];
    logic        fd     [2];
    logic        busy   [2];
    logic        ov     [2];
    logic        to     [2];
    int          m_cnt  [2][4];
    int          m_len  [2][4];

    sprite_draw_sequencer #(
        .NUM_SPRITES(4), .FRAME_CYCLES(4000), .CLEAR_EN(0),
        .SCREEN_W(8), .SCREEN_H(4), .BG_COLOUR(3'b000), .TIMEOUT(600)
    ) dut_b (
        .clk(clk), .resetn(rst_m[0]),
        .sprite_active(m_act[0]), .sprite_done(m_done[0]),
        .sprite_x(m_x[0]), .sprite_y(m_y[0]), .sprite_colour(m_c[0]),
        .sprite_enable(m_en[0]), .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]),
        .vga_plot(plot[0]), .frame_done(fd[0]), .busy(busy[0]),
        .overrun(ov[0]), .timeout_err(to[0])
    );

    sprite_draw_sequencer #(
        .NUM_SPRITES(4), .FRAME_CYCLES(1000), .CLEAR_EN(0),
        .SCREEN_W(8), .SCREEN_H(4), .BG_COLOUR(3'b000), .TIMEOUT(600)
    ) dut_c (
        .clk(clk), .resetn(rst_m[1]),
        .sprite_active(m_act[1]), .sprite_done(m_done[1]),
        .sprite_x(m_x[1]), .sprite_y(m_y[1]), .sprite_colour(m_c[1]),
        .sprite_enable(m_en[1]), .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]),
        .vga_plot(plot[1]), .frame_done(fd[1]), .busy(busy[1]),
        .overrun(ov[1]), .timeout_err(to[1])
    );

    // plotter models: pixel n of slot k is (k*80 + n%80, n/80) colour k+1;
    // done on pixel m_len-1 (m_len 0 = never), done reads 1 while disabled
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                m_cnt[d][k] <= m_en[d][k] ? m_cnt[d][k] + 1 : 0;
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            m_done[d] = '0;
            m_x[d]    = '0;
            m_y[d]    = '0;
            m_c[d]    = '0;
            for (int k = 0; k < 4; k++) begin
                m_done[d][k]      = !m_en[d][k] || (m_len[d][k] != 0 && m_cnt[d][k] == m_len[d][k] - 1);
                m_x[d][9*k +: 9]  = 9'(k*80 + m_cnt[d][k] % 80);
                m_y[d][8*k +: 8]  = 8'(m_cnt[d][k] / 80);
                m_c[d][3*k +: 3]  = 3'(k + 1);
            end
        end
    end

    // observer on instance b
    logic        mon_clear;
    int          b_plot_cnt, b_viol, b_pix_err, b_ord_n, b_fall2_cyc, b_fd_cyc;
    int          b_en_cnt [4];
    logic [15:0] b_ord_code;
    logic [3:0]  b_prev_en;
    logic [19:0] b_prev_pix, b_first_pix, b_last_pix;
    logic        b_first_seen;

    always @(negedge clk) begin
        if (mon_clear) begin
            b_plot_cnt = 0; b_viol = 0; b_pix_err = 0; b_ord_n = 0;
            b_fall2_cyc = 0; b_fd_cyc = 0; b_ord_code = '0;
            b_first_seen = 1'b0; b_first_pix = '0; b_last_pix = '0;
            for (int k = 0; k < 4; k++) b_en_cnt[k] = 0;
        end else begin
            if (plot[0]) begin
                b_plot_cnt++;
                if (b_prev_en == 4'b0000 || {vx[0], vy[0], vc[0]} !== b_prev_pix) b_pix_err++;
                if (!b_first_seen) begin
                    b_first_pix  = {vx[0], vy[0], vc[0]};
                    b_first_seen = 1'b1;
                end
                b_last_pix = {vx[0], vy[0], vc[0]};
            end
            for (int k = 0; k < 4; k++) begin
                if (m_en[0][k]) b_en_cnt[k]++;
                if (m_en[0][k] && !b_prev_en[k]) begin
                    b_ord_code = {b_ord_code[11:0], 4'(k)};
                    b_ord_n++;
                end
                if (k == 2 && !m_en[0][k] && b_prev_en[k]) b_fall2_cyc = cyc;
            end
            if ($countones(m_en[0]) > 1) b_viol++;
            if (m_en[0] != 4'b0000 && !busy[0]) b_viol++;
            if (fd[0]) b_fd_cyc = cyc;
        end
        b_prev_en  = m_en[0];
        b_prev_pix = '0;
        for (int k = 0; k < 4; k++)
            if (m_en[0][k]) b_prev_pix = {m_x[0][9*k +: 9], m_y[0][8*k +: 8], m_c[0][3*k +: 3]};
    end

    task automatic clear_monitor();
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
    endtask

    // configure instance b and run one complete frame
    task automatic run_b_frame(input logic [3:0] act, input int l0, input int l1, input int l2, input int l3);
        int n;
        m_act[0] = act;
        m_len[0][0] = l0; m_len[0][1] = l1; m_len[0][2] = l2; m_len[0][3] = l3;
        clear_monitor();
        n = 0;
        while (!busy[0] && n < 4100) begin @(negedge clk); n++; end
        n_checks++;
        if (!busy[0]) begin n_fail++; $display("FAIL b_frame_start busy=%0b required 1", busy[0]); end
        n = 0;
        while (!fd[0] && n < 4100) begin @(negedge clk); n++; end
        n_checks++;
        if (!fd[0]) begin n_fail++; $display("FAIL b_frame_done frame_done=%0b required 1", fd[0]); end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_m[0] = 1'b0; rst_m[1] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_en, a_vx, a_vy, a_vc, a_plot, a_fd, a_busy, a_ov, a_to} !== '0) begin
            n_fail++; $display("FAIL reset_a outputs=%h required 0", {a_en, a_vx, a_vy, a_vc, a_plot, a_fd, a_busy, a_ov, a_to});
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({m_en[d], vx[d], vy[d], vc[d], plot[d], fd[d], busy[d], ov[d], to[d]} !== '0) begin
                n_fail++; $display("FAIL reset_%0d outputs=%h required 0", d, {m_en[d], vx[d], vy[d], vc[d], plot[d], fd[d], busy[d], ov[d], to[d]});
            end
        end
    endtask

    task automatic test_clear();
        int n;
        rst_a = 1'b1;
        n = 0;
        while (!a_plot && n < 4100) begin @(negedge clk); n++; end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if ({a_plot, a_vx, a_vy, a_vc} !== {1'b1, 9'(i % 8), 8'(i / 8), 3'b000}) begin
                n_fail++;
                $display("FAIL clear_px%0d plot=%0b x=%0d y=%0d c=%0d required plot=1 x=%0d y=%0d c=0",
                         i, a_plot, a_vx, a_vy, a_vc, i % 8, i / 8);
            end
            @(negedge clk);
        end
        n_checks++;
        if (a_plot !== 1'b0) begin n_fail++; $display("FAIL clear_end plot=%0b required 0", a_plot); end
        n = 0;
        while (!a_fd && n < 10) begin @(negedge clk); n++; end
        n_checks++;
        if (a_fd !== 1'b1 || a_plot !== 1'b0 || a_en !== 4'b0000) begin
            n_fail++; $display("FAIL clear_frame_done fd=%0b plot=%0b en=%b required 1 0 0000", a_fd, a_plot, a_en);
        end
        @(negedge clk);
        n_checks++;
        if ({a_fd, a_busy} !== 2'b00) begin
            n_fail++; $display("FAIL clear_idle fd_busy=%b required 00", {a_fd, a_busy});
        end
    endtask

    task automatic test_all_slots();
        rst_m[0] = 1'b1;
        run_b_frame(4'b1111, 560, 560, 560, 560);
        n_checks++;
        if (b_plot_cnt != 2240) begin n_fail++; $display("FAIL all_plot_count got %0d required 2240", b_plot_cnt); end
        n_checks++;
        if (b_ord_n != 4 || b_ord_code !== 16'h0123) begin
            n_fail++; $display("FAIL all_order got n=%0d code=%h required 4 0123", b_ord_n, b_ord_code);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (b_en_cnt[k] != 560) begin n_fail++; $display("FAIL all_en_cycles%0d got %0d required 560", k, b_en_cnt[k]); end
        end
        n_checks++;
        if (b_viol != 0 || b_pix_err != 0) begin
            n_fail++; $display("FAIL all_onehot_pixels viol=%0d pix_err=%0d required 0 0", b_viol, b_pix_err);
        end
        n_checks++;
        if (b_first_pix !== {9'd0, 8'd0, 3'd1} || b_last_pix !== {9'd319, 8'd6, 3'd4}) begin
            n_fail++; $display("FAIL all_first_last got %h %h required %h %h", b_first_pix, b_last_pix,
                               {9'd0, 8'd0, 3'd1}, {9'd319, 8'd6, 3'd4});
        end
        n_checks++;
        if ({ov[0], to[0]} !== 2'b00) begin n_fail++; $display("FAIL all_flags ov_to=%b required 00", {ov[0], to[0]}); end
    endtask

    task automatic test_sparse();
        run_b_frame(4'b0101, 560, 560, 560, 560);
        n_checks++;
        if (b_en_cnt[0] != 560 || b_en_cnt[1] != 0 || b_en_cnt[2] != 560 || b_en_cnt[3] != 0) begin
            n_fail++; $display("FAIL sparse_en_cycles got %0d %0d %0d %0d required 560 0 560 0",
                               b_en_cnt[0], b_en_cnt[1], b_en_cnt[2], b_en_cnt[3]);
        end
        n_checks++;
        if (b_ord_n != 2 || b_ord_code !== 16'h0002) begin
            n_fail++; $display("FAIL sparse_order got n=%0d code=%h required 2 0002", b_ord_n, b_ord_code);
        end
        n_checks++;
        if (b_plot_cnt != 1120 || b_last_pix !== {9'd239, 8'd6, 3'd3}) begin
            n_fail++; $display("FAIL sparse_plots got %0d last=%h required 1120 %h", b_plot_cnt, b_last_pix, {9'd239, 8'd6, 3'd3});
        end
        n_checks++;
        if (b_fd_cyc - b_fall2_cyc != 2) begin
            n_fail++; $display("FAIL sparse_fd_latency got %0d required 2", b_fd_cyc - b_fall2_cyc);
        end
    endtask

    task automatic test_timeout();
        run_b_frame(4'b1111, 100, 0, 100, 100);
        n_checks++;
        if (b_en_cnt[0] != 100 || b_en_cnt[1] != 600 || b_en_cnt[2] != 100 || b_en_cnt[3] != 100) begin
            n_fail++; $display("FAIL timeout_en_cycles got %0d %0d %0d %0d required 100 600 100 100",
                               b_en_cnt[0], b_en_cnt[1], b_en_cnt[2], b_en_cnt[3]);
        end
        n_checks++;
        if (to[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %0b required 1", to[0]); end
        n_checks++;
        if (b_ord_code !== 16'h0123 || b_plot_cnt != 900 || b_last_pix !== {9'd259, 8'd1, 3'd4}) begin
            n_fail++; $display("FAIL timeout_continue order=%h plots=%0d last=%h required 0123 900 %h",
                               b_ord_code, b_plot_cnt, b_last_pix, {9'd259, 8'd1, 3'd4});
        end
    endtask

    task automatic test_reset_mid_draw();
        int n;
        m_act[0] = 4'b1111;
        for (int k = 0; k < 4; k++) m_len[0][k] = 560;
        n = 0;
        while (!m_en[0][2] && n < 8000) begin @(negedge clk); n++; end
        n_checks++;
        if (m_en[0][2] !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_slot2 en=%b required bit2 set", m_en[0]); end
        repeat (100) @(negedge clk);
        rst_m[0] = 1'b0;
        @(posedge clk);
        #1;
        mon_clear = 1'b1;
        n_checks++;
        if ({m_en[0], plot[0], busy[0], ov[0], to[0], fd[0]} !== 9'd0) begin
            n_fail++; $display("FAIL midreset_outputs en=%b plot=%0b busy=%0b ov=%0b to=%0b fd=%0b required all 0",
                               m_en[0], plot[0], busy[0], ov[0], to[0], fd[0]);
        end
        @(negedge clk);
        rst_m[0] = 1'b1;
        n = 0;
        while (n < 4100) begin
            @(posedge clk);
            #1;
            mon_clear = 1'b0;
            n++;
            if (busy[0]) break;
        end
        n_checks++;
        if (n < 4000 || n > 4002) begin n_fail++; $display("FAIL midreset_restart_edges got %0d required 4000..4002", n); end
        n = 0;
        while (!fd[0] && n < 4100) begin @(negedge clk); n++; end
        @(negedge clk);
        #1;
        n_checks++;
        if (b_plot_cnt != 2240 || b_ord_code !== 16'h0123 || b_viol != 0 || b_pix_err != 0) begin
            n_fail++; $display("FAIL midreset_resume plots=%0d order=%h viol=%0d pix_err=%0d required 2240 0123 0 0",
                               b_plot_cnt, b_ord_code, b_viol, b_pix_err);
        end
    endtask

    task automatic test_overrun();
        int n, t1, t2;
        m_act[1] = 4'b1111;
        for (int k = 0; k < 4; k++) m_len[1][k] = 560;
        rst_m[1] = 1'b1;
        n = 0;
        while (!busy[1] && n < 1100) begin @(negedge clk); n++; end
        t1 = cyc;
        n_checks++;
        if (busy[1] !== 1'b1 || ov[1] !== 1'b0) begin
            n_fail++; $display("FAIL overrun_start busy=%0b ov=%0b required 1 0", busy[1], ov[1]);
        end
        n = 0;
        while (!fd[1] && n < 3000) begin @(negedge clk); n++; end
        n_checks++;
        if (fd[1] !== 1'b1 || ov[1] !== 1'b1) begin
            n_fail++; $display("FAIL overrun_flag fd=%0b ov=%0b required 1 1", fd[1], ov[1]);
        end
        n = 0;
        while (busy[1] && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (!busy[1] && n < 1100) begin @(negedge clk); n++; end
        t2 = cyc;
        n_checks++;
        if (t2 - t1 != 3000 || ov[1] !== 1'b1) begin
            n_fail++; $display("FAIL overrun_next_frame period=%0d ov=%0b required 3000 1", t2 - t1, ov[1]);
        end
    endtask

    initial begin
        mon_clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 4'b0000;
            for (int k = 0; k < 4; k++) m_len[d][k] = 560;
        end
        test_reset();
        test_clear();
        test_all_slots();
        test_sparse();
        test_timeout();
        test_reset_mid_draw();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
